// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared FSM state encoding, operation codes and default width
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int NBYTES_DEFAULT = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/Full_adder_8bit.sv
`default_nettype none
// ============================================================================
// Module   : Full_adder_8bit
// Purpose  : 8-bit ripple-carry adder built from single-bit full-adder cells
// Revision : 1.0  initial release
// ============================================================================
module Full_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[8];

endmodule
`default_nettype wire

// File: rtl/alu_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_add_seq
// Purpose  : Byte-serial W-bit add/subtract through one shared 8-bit adder
// Revision : 1.0  initial release
// ============================================================================
module alu_add_seq
    import alu_pkg::*;
#(
    parameter  int NBYTES = NBYTES_DEFAULT,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int            KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_op;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_ovf;

    logic [7:0]    w_a_byte;
    logic [7:0]    w_b_byte;
    logic [7:0]    w_sum;
    logic          w_cout;
    logic          w_b_msb;

    // Subtraction is A + ~B + 1: invert B here, the +1 comes from the carry load
    assign w_a_byte = r_a[{r_k, 3'b000} +: 8];
    assign w_b_byte = r_b[{r_k, 3'b000} +: 8] ^ {8{r_op == OP_SUB}};
    assign w_b_msb  = r_b[W-1] ^ (r_op == OP_SUB);

    Full_adder_8bit u_adder (
        .a    (w_a_byte),
        .b    (w_b_byte),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op_sub;
                        r_k     <= '0;
                        r_carry <= op_sub;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_result[{r_k, 3'b000} +: 8] <= w_sum;
                    r_carry <= w_cout;
                    r_k     <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_state <= DONE;
                        r_cout  <= w_cout;
                        r_ovf   <= (r_a[W-1] == w_b_msb) && (w_sum[7] != r_a[W-1]);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;
    assign zero   = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_add_seq
// Purpose  : Self-checking bench for alu_add_seq against an arithmetic model
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_add_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int           m_cnt  = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_res  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W-1:0] p_res;
    logic         p_cout, p_ovf;

    alu_add_seq #(.NBYTES(NBYTES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: unsigned for result/carry, signed range for overflow
    task automatic compute(input logic [W-1:0] pa, input logic [W-1:0] pb, input logic sub);
        longint    ua, ub, sa, sb, st, maxv, minv;
        logic [63:0] tmp;
        ua = longint'(pa);
        ub = longint'(pb);
        sa = longint'($signed(pa));
        sb = longint'($signed(pb));
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        tmp = sub ? (ua - ub) : (ua + ub);
        p_res  = tmp[W-1:0];
        p_cout = sub ? (ua >= ub) : ((ua + ub) >= (longint'(1) <<< W));
        st = sub ? (sa - sb) : (sa + sb);
        p_ovf = (st > maxv) || (st < minv);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_done = 1'b0; m_res = '0; m_cout = 1'b0; m_ovf = 1'b0;
        end else if (m_cnt == 0 && start) begin
            compute(a, b, op_sub);
            m_cnt  = NBYTES;
            m_done = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            m_done = (m_cnt == 0);
            if (m_done) begin
                m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_cnt != 0));
            chk("done", 64'(done), 64'(m_done));
            if (m_cnt == 0) begin
                chk("result", 64'(result), 64'(m_res));
                chk("cout",   64'(cout),   64'(m_cout));
                chk("ovf",    64'(ovf),    64'(m_ovf));
                chk("zero",   64'(zero),   64'(m_res == '0));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub);
        start = 1'b1; a = ia; b = ib; op_sub = isub;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_check(input string name, input int lat0, input logic [W-1:0] er,
                                input logic ec, input logic eo, input logic ez);
        int lat;
        lat = lat0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(NBYTES + 1));
        chk({name, "_result"},  64'(result), 64'(er));
        chk({name, "_cout"},    64'(cout), 64'(ec));
        chk({name, "_ovf"},     64'(ovf), 64'(eo));
        chk({name, "_zero"},    64'(zero), 64'(ez));
    endtask

    initial begin
        logic [W-1:0] corners [6];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = {1'b1, {(W-1){1'b0}}};
        corners[3] = {1'b0, {(W-1){1'b1}}};
        corners[4] = W'(1);
        corners[5] = W'(255);

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_zero", 64'(zero), 64'(1));
        rst = 1'b0;

        @(negedge clk);
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0);
        finish_check("add_ff_1", 1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        finish_check("add_wrap", 1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        finish_check("add_ovf", 1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        issue(32'h8000_0000, 32'h0000_0001, 1'b1);
        finish_check("sub_ovf", 1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        // Back-to-back start issued in the DONE cycle
        issue(32'h0000_0005, 32'h0000_0007, 1'b1);
        finish_check("sub_5_7", 1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Start during RUN with new operands must be ignored
        @(negedge clk);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        start = 1'b1; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; op_sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_check("ignore_start", 2, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

        // Reset after two RUN edges aborts the operation
        @(negedge clk);
        issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",   64'(busy),   64'(0));
        chk("abort_done",   64'(done),   64'(0));
        chk("abort_result", 64'(result), 64'(0));
        chk("abort_zero",   64'(zero),   64'(1));
        repeat (8) @(negedge clk);
        issue(32'h0000_0003, 32'h0000_0004, 1'b0);
        finish_check("after_abort", 1, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 199) == 0);
            start  = ($urandom_range(0, 2) == 0);
            op_sub = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
